// File: rtl/tap_shift_pkg.sv
// Shared types and helpers for the tap shift register.
// Holds the resolved command encoding and the priority function
// that turns the raw clear/load/shift strobes into one command.
package tap_shift_pkg;

  typedef enum logic [1:0] {
    CMD_HOLD  = 2'd0,
    CMD_SHIFT = 2'd1,
    CMD_LOAD  = 2'd2,
    CMD_CLEAR = 2'd3
  } cmd_e;

  // Priority: clear beats load beats shift; nothing asserted means hold.
  function automatic cmd_e resolve_cmd(input logic clear,
                                       input logic load_en,
                                       input logic shift_en);
    cmd_e cmd;
    if (clear)         cmd = CMD_CLEAR;
    else if (load_en)  cmd = CMD_LOAD;
    else if (shift_en) cmd = CMD_SHIFT;
    else               cmd = CMD_HOLD;
    return cmd;
  endfunction

endpackage

// File: rtl/tap_shift_register_mux.sv
// Read tap for the tap shift register: DEPTH:1 mux over WIDTH-bit
// entries, forcing zero/invalid for addresses past the last entry.
// Build option TAP_REG_EN: registers tap_data/tap_valid (one extra
// cycle of latency, sync reset to zero); otherwise purely combinational.
module tap_shift_mux
  import tap_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
`ifdef TAP_REG_EN
  input  logic                   clk,
  input  logic                   rst,
`endif
  input  logic [DEPTH*WIDTH-1:0] entries,
  input  logic [AW-1:0]          addr,
  input  logic [CW-1:0]          fill,
  output logic [WIDTH-1:0]       tap_data,
  output logic                   tap_valid
);

  logic [31:0]      addr_ext;
  logic [31:0]      fill_ext;
  logic             in_range;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;

  assign addr_ext = 32'(addr);
  assign fill_ext = 32'(fill);
  assign in_range = (addr_ext < 32'(DEPTH));

  // Select entry[addr]; out-of-range addresses match no entry and read zero.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr_ext == 32'(i)) sel_data = entries[i*WIDTH +: WIDTH];
    end
    sel_valid = in_range && (addr_ext < fill_ext);
  end

`ifdef TAP_REG_EN
  // Registered tap: captures the selection made with the previous edge's state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap_data  <= '0;
      tap_valid <= 1'b0;
    end else begin
      tap_data  <= sel_data;
      tap_valid <= sel_valid;
    end
  end
`else
  assign tap_data  = sel_data;
  assign tap_valid = sel_valid;
`endif

endmodule

// File: rtl/tap_shift_register.sv
// Parametrised DEPTH x WIDTH shift register with addressable read tap,
// parallel load, clear and saturating fill count. Entry 0 is newest.
// Build option TAP_REG_EN: registered read tap (see tap_shift_mux).
module tap_shift_register
  import tap_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   load_en,
  input  logic [DEPTH*WIDTH-1:0] load_data,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       shift_in,
  input  logic [AW-1:0]          addr,
  output logic [WIDTH-1:0]       tap_data,
  output logic                   tap_valid,
  output logic [WIDTH-1:0]       shift_out,
  output logic [CW-1:0]          fill,
  output logic                   full
);

  localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] entries_flat;
  cmd_e                   cmd;

  assign cmd = resolve_cmd(clear, load_en, shift_en);

  // Entry storage: reset/clear zero everything, load replaces all, shift moves toward DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (cmd)
        CMD_CLEAR: for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        CMD_LOAD:  for (int i = 0; i < DEPTH; i++) mem[i] <= load_data[i*WIDTH +: WIDTH];
        CMD_SHIFT: begin
          mem[0] <= shift_in;
          for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
        end
        default: ;
      endcase
    end
  end

  // Fill count: saturates at DEPTH on shift so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill <= '0;
    end else begin
      case (cmd)
        CMD_CLEAR: fill <= '0;
        CMD_LOAD:  fill <= FILL_MAX;
        CMD_SHIFT: if (fill != FILL_MAX) fill <= fill + 1'b1;
        default: ;
      endcase
    end
  end

  // Flatten the entry array for the read mux.
  always_comb begin
    entries_flat = '0;
    for (int i = 0; i < DEPTH; i++) entries_flat[i*WIDTH +: WIDTH] = mem[i];
  end

  assign shift_out = mem[DEPTH-1];
  assign full      = (fill == FILL_MAX);

  tap_shift_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW),
    .CW    (CW)
  ) u_mux (
`ifdef TAP_REG_EN
    .clk       (clk),
    .rst       (rst),
`endif
    .entries   (entries_flat),
    .addr      (addr),
    .fill      (fill),
    .tap_data  (tap_data),
    .tap_valid (tap_valid)
  );

endmodule

// File: tb/tb_tap_shift_register.sv
// Directed self-checking bench for tap_shift_register (DEPTH=8 and DEPTH=6).
// When built with TAP_REG_EN the tap checks wait one extra edge.
module tb_tap_shift_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear, load_en, shift_en;
  logic [63:0] load_data;
  logic [7:0]  shift_in;
  logic [2:0]  addr;
  logic [7:0]  tap_data, shift_out;
  logic        tap_valid, full;
  logic [3:0]  fill;

  logic        clear6, load_en6, shift_en6;
  logic [47:0] load_data6;
  logic [7:0]  shift_in6;
  logic [2:0]  addr6;
  logic [7:0]  tap_data6, shift_out6;
  logic        tap_valid6, full6;
  logic [2:0]  fill6;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  tap_shift_register #(.WIDTH(8), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load_en(load_en), .load_data(load_data),
    .shift_en(shift_en), .shift_in(shift_in), .addr(addr), .tap_data(tap_data),
    .tap_valid(tap_valid), .shift_out(shift_out), .fill(fill), .full(full)
  );

  tap_shift_register #(.WIDTH(8), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .clear(clear6), .load_en(load_en6), .load_data(load_data6),
    .shift_en(shift_en6), .shift_in(shift_in6), .addr(addr6), .tap_data(tap_data6),
    .tap_valid(tap_valid6), .shift_out(shift_out6), .fill(fill6), .full(full6)
  );

  // Advance one edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let the tap catch up with the current addr/contents.
  task automatic settle();
`ifdef TAP_REG_EN
    step();
`else
    #1;
`endif
  endtask

  task automatic idle();
    clear = 0; load_en = 0; shift_en = 0;
    clear6 = 0; load_en6 = 0; shift_en6 = 0;
  endtask

  task automatic do_shift(input logic [7:0] v);
    shift_en = 1; shift_in = v;
    step();
    shift_en = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    addr = 3'd0;
    settle();
    checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL reset_fill got %0d want 0", fill); end
    checks++; if (full !== 1'b0) begin fails++; $display("[TB] FAIL reset_full got %b want 0", full); end
    checks++; if (tap_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_tap got %h want 00", tap_data); end
    checks++; if (tap_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", tap_valid); end
    checks++; if (shift_out !== 8'h00) begin fails++; $display("[TB] FAIL reset_shift_out got %h want 00", shift_out); end
  endtask

  task automatic test_shift();
    do_reset();
    do_shift(8'h11); do_shift(8'h22); do_shift(8'h33);
    addr = 3'd0; settle();
    checks++; if (tap_data !== 8'h33) begin fails++; $display("[TB] FAIL shift_addr0 got %h want 33", tap_data); end
    checks++; if (tap_valid !== 1'b1) begin fails++; $display("[TB] FAIL shift_valid0 got %b want 1", tap_valid); end
    addr = 3'd2; settle();
    checks++; if (tap_data !== 8'h11) begin fails++; $display("[TB] FAIL shift_addr2 got %h want 11", tap_data); end
    checks++; if (fill !== 4'd3) begin fails++; $display("[TB] FAIL shift_fill got %0d want 3", fill); end
    addr = 3'd3; settle();
    checks++; if (tap_valid !== 1'b0) begin fails++; $display("[TB] FAIL shift_valid3 got %b want 0", tap_valid); end
    checks++; if (tap_data !== 8'h00) begin fails++; $display("[TB] FAIL shift_addr3 got %h want 00", tap_data); end
    // Hold: a few idle edges change nothing.
    step(); step();
    addr = 3'd1; settle();
    checks++; if (tap_data !== 8'h22) begin fails++; $display("[TB] FAIL hold_addr1 got %h want 22", tap_data); end
    checks++; if (fill !== 4'd3) begin fails++; $display("[TB] FAIL hold_fill got %0d want 3", fill); end
  endtask

`ifdef TAP_REG_EN
  // The registered tap still shows the old selection right after an addr change.
  task automatic test_tap_latency();
    do_reset();
    do_shift(8'h11); do_shift(8'h22); do_shift(8'h33);
    addr = 3'd0; step();
    addr = 3'd2; #1;
    checks++; if (tap_data !== 8'h33) begin fails++; $display("[TB] FAIL lat_old got %h want 33", tap_data); end
    step();
    checks++; if (tap_data !== 8'h11) begin fails++; $display("[TB] FAIL lat_new got %h want 11", tap_data); end
    // Two edges from a shift: the shift edge, then the tap register edge.
    addr = 3'd0;
    step();
    shift_en = 1; shift_in = 8'h44; step(); shift_en = 0;
    checks++; if (tap_data !== 8'h33) begin fails++; $display("[TB] FAIL lat_shift1 got %h want 33", tap_data); end
    step();
    checks++; if (tap_data !== 8'h44) begin fails++; $display("[TB] FAIL lat_shift2 got %h want 44", tap_data); end
  endtask
`endif

  task automatic test_saturate();
    do_reset();
    for (int v = 1; v <= 10; v++) do_shift(8'(v));
    addr = 3'd7; settle();
    checks++; if (fill !== 4'd8) begin fails++; $display("[TB] FAIL sat_fill got %0d want 8", fill); end
    checks++; if (full !== 1'b1) begin fails++; $display("[TB] FAIL sat_full got %b want 1", full); end
    checks++; if (shift_out !== 8'h03) begin fails++; $display("[TB] FAIL sat_shift_out got %h want 03", shift_out); end
    checks++; if (tap_data !== 8'h03) begin fails++; $display("[TB] FAIL sat_addr7 got %h want 03", tap_data); end
    addr = 3'd0; settle();
    checks++; if (tap_data !== 8'h0A) begin fails++; $display("[TB] FAIL sat_addr0 got %h want 0a", tap_data); end
  endtask

  task automatic test_load_over_shift();
    logic [7:0] want;
    for (int i = 0; i < 8; i++) load_data[i*8 +: 8] = 8'hA0 + 8'(i);
    load_en = 1; shift_en = 1; shift_in = 8'h5A;
    step();
    load_en = 0; shift_en = 0;
    checks++; if (fill !== 4'd8) begin fails++; $display("[TB] FAIL load_fill got %0d want 8", fill); end
    checks++; if (shift_out !== 8'hA7) begin fails++; $display("[TB] FAIL load_shift_out got %h want a7", shift_out); end
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i); settle();
      want = 8'hA0 + 8'(i);
      checks++;
      if (tap_data !== want || tap_valid !== 1'b1) begin
        fails++; $display("[TB] FAIL load_entry%0d got %h/%b want %h/1", i, tap_data, tap_valid, want);
      end
    end
  endtask

  task automatic test_clear_over_load();
    for (int i = 0; i < 8; i++) load_data[i*8 +: 8] = 8'hF0 + 8'(i);
    clear = 1; load_en = 1;
    step();
    clear = 0; load_en = 0;
    addr = 3'd0; settle();
    checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL clr_fill got %0d want 0", fill); end
    checks++; if (full !== 1'b0) begin fails++; $display("[TB] FAIL clr_full got %b want 0", full); end
    checks++; if (tap_valid !== 1'b0) begin fails++; $display("[TB] FAIL clr_valid got %b want 0", tap_valid); end
    checks++; if (tap_data !== 8'h00) begin fails++; $display("[TB] FAIL clr_tap got %h want 00", tap_data); end
    checks++; if (shift_out !== 8'h00) begin fails++; $display("[TB] FAIL clr_shift_out got %h want 00", shift_out); end
  endtask

  task automatic test_reset_mid_shift();
    do_reset();
    do_shift(8'h61); do_shift(8'h62); do_shift(8'h63);
    addr = 3'd0;
    shift_en = 1; shift_in = 8'h5A; rst = 1;
    step();
    rst = 0; shift_en = 0;
    checks++; if (fill !== 4'd0) begin fails++; $display("[TB] FAIL rstmid_fill got %0d want 0", fill); end
    checks++; if (shift_out !== 8'h00) begin fails++; $display("[TB] FAIL rstmid_shift_out got %h want 00", shift_out); end
    checks++; if (tap_data !== 8'h00) begin fails++; $display("[TB] FAIL rstmid_tap got %h want 00", tap_data); end
    checks++; if (tap_valid !== 1'b0) begin fails++; $display("[TB] FAIL rstmid_valid got %b want 0", tap_valid); end
    settle();
    checks++; if (tap_data !== 8'h00) begin fails++; $display("[TB] FAIL rstmid_no_capture got %h want 00", tap_data); end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 6; i++) load_data6[i*8 +: 8] = 8'hC0 + 8'(i);
    load_en6 = 1;
    step();
    load_en6 = 0;
    checks++; if (fill6 !== 3'd6 || full6 !== 1'b1) begin fails++; $display("[TB] FAIL d6_fill got %0d/%b want 6/1", fill6, full6); end
    addr6 = 3'd5; settle();
    checks++; if (tap_data6 !== 8'hC5 || tap_valid6 !== 1'b1) begin fails++; $display("[TB] FAIL d6_addr5 got %h/%b want c5/1", tap_data6, tap_valid6); end
    addr6 = 3'd6; settle();
    checks++; if (tap_data6 !== 8'h00 || tap_valid6 !== 1'b0) begin fails++; $display("[TB] FAIL d6_addr6 got %h/%b want 00/0", tap_data6, tap_valid6); end
    addr6 = 3'd7; settle();
    checks++; if (tap_data6 !== 8'h00 || tap_valid6 !== 1'b0) begin fails++; $display("[TB] FAIL d6_addr7 got %h/%b want 00/0", tap_data6, tap_valid6); end
    checks++; if (shift_out6 !== 8'hC5) begin fails++; $display("[TB] FAIL d6_shift_out got %h want c5", shift_out6); end
  endtask

  initial begin
    rst = 1; idle();
    load_data = '0; shift_in = '0; addr = '0;
    load_data6 = '0; shift_in6 = '0; addr6 = '0;
    test_reset();
    test_shift();
`ifdef TAP_REG_EN
    test_tap_latency();
`endif
    test_saturate();
    test_load_over_shift();
    test_clear_over_load();
    test_reset_mid_shift();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
